// File: rtl/rectify_sequencer.sv
// Frame-level controller for the rectification datapath: accepts a corner quad,
// holds it stable for the parameter solver, then sequences latch, transform and bank swap.
module rectify_sequencer #(
    parameter int SETTLE_CYCLES  = 8,
    parameter int TIMEOUT_CYCLES = 200_000_000,
    parameter int XMAX           = 639,
    parameter int YMAX           = 479
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       corners_valid,
    output logic       corners_ready,
    input  logic [9:0] x1_in,
    input  logic [9:0] x2_in,
    input  logic [9:0] x3_in,
    input  logic [9:0] x4_in,
    input  logic [8:0] y1_in,
    input  logic [8:0] y2_in,
    input  logic [8:0] y3_in,
    input  logic [8:0] y4_in,
    output logic [9:0] x1_out,
    output logic [9:0] x2_out,
    output logic [9:0] x3_out,
    output logic [9:0] x4_out,
    output logic [8:0] y1_out,
    output logic [8:0] y2_out,
    output logic [8:0] y3_out,
    output logic [8:0] y4_out,
    output logic       params_latch,
    output logic       xform_start,
    input  logic       xform_done,
    output logic       bank_sel,
    output logic       busy,
    output logic       frame_valid,
    output logic       err_range,
    output logic       err_timeout
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [9:0]       X_LIMIT  = 10'(XMAX);
    localparam logic [8:0]       Y_LIMIT  = 9'(YMAX);

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        LATCH,
        START,
        WAIT_LOW,
        RUN,
        SWAP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [TMO_W-1:0] tmo;
    logic             accept;
    logic             in_range;
    logic             tmo_expired;

    assign in_range = (x1_in <= X_LIMIT) && (x2_in <= X_LIMIT) &&
                      (x3_in <= X_LIMIT) && (x4_in <= X_LIMIT) &&
                      (y1_in <= Y_LIMIT) && (y2_in <= Y_LIMIT) &&
                      (y3_in <= Y_LIMIT) && (y4_in <= Y_LIMIT);

    assign accept      = corners_valid && (state == IDLE);
    assign tmo_expired = (tmo == TMO_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A done level seen in RUN beats a timeout expiring in the same cycle.
    always_comb begin
        state_next    = state;
        corners_ready = 1'b0;
        busy          = 1'b1;
        params_latch  = 1'b0;
        xform_start   = 1'b0;
        frame_valid   = 1'b0;
        err_timeout   = 1'b0;
        case (state)
            IDLE: begin
                corners_ready = 1'b1;
                busy          = 1'b0;
                if (corners_valid && in_range) begin
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == '0) begin
                    state_next = LATCH;
                end
            end
            LATCH: begin
                params_latch = 1'b1;
                state_next   = START;
            end
            START: begin
                xform_start = 1'b1;
                state_next  = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (tmo_expired) begin
                    err_timeout = 1'b1;
                    state_next  = IDLE;
                end else if (!xform_done) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (xform_done) begin
                    state_next = SWAP;
                end else if (tmo_expired) begin
                    err_timeout = 1'b1;
                    state_next  = IDLE;
                end
            end
            SWAP: begin
                frame_valid = 1'b1;
                state_next  = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Corners are captured only on an accepted in-range quad and stay frozen until the next one.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x1_out <= '0;
            x2_out <= '0;
            x3_out <= '0;
            x4_out <= '0;
            y1_out <= '0;
            y2_out <= '0;
            y3_out <= '0;
            y4_out <= '0;
        end else if (accept && in_range) begin
            x1_out <= x1_in;
            x2_out <= x2_in;
            x3_out <= x3_in;
            x4_out <= x4_in;
            y1_out <= y1_in;
            y2_out <= y2_in;
            y3_out <= y3_in;
            y4_out <= y4_in;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (accept && in_range) begin
            cnt <= CNT_INIT;
        end else if (state == SETTLE && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // The timeout counter never wraps: both waiting states leave when it reaches its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tmo <= '0;
        end else if (state == START) begin
            tmo <= '0;
        end else if (state == WAIT_LOW || state == RUN) begin
            tmo <= tmo + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bank_sel  <= 1'b0;
            err_range <= 1'b0;
        end else begin
            err_range <= accept && !in_range;
            if (state == SWAP) begin
                bank_sel <= ~bank_sel;
            end
        end
    end

endmodule

// File: tb/tb_rectify_sequencer.sv
// Randomized scoreboard bench for rectify_sequencer with a transaction-level timing model
// and a behavioural pixel_transform done responder.
`timescale 1ns/1ps
module tb_rectify_sequencer;

    localparam int S     = 8;
    localparam int TMO   = 100;
    localparam int NEVER = 1_000_000;

    typedef struct packed {
        logic [3:0][9:0] x;
        logic [3:0][8:0] y;
    } quad_t;

    typedef enum int {EV_LATCH, EV_START, EV_FRAME, EV_RANGE, EV_TMO} ev_kind_t;

    typedef struct {
        ev_kind_t kind;
        int       cyc;
        logic     bank;
    } ev_t;

    typedef struct {
        int hold;
        int low;
    } prof_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       corners_valid = 1'b0;
    logic       corners_ready;
    quad_t      drive_q = '0;
    logic [9:0] x1_out, x2_out, x3_out, x4_out;
    logic [8:0] y1_out, y2_out, y3_out, y4_out;
    logic       params_latch, xform_start, xform_done = 1'b0;
    logic       bank_sel, busy, frame_valid, err_range, err_timeout;

    int    cyc = 0;
    int    total = 0;
    int    bad = 0;
    ev_t   exp_q[$];
    prof_t prof_q[$];
    logic  model_bank = 1'b0;
    quad_t last_quad = '0;
    int    last_ts = 0;
    bit    done_active = 1'b0;
    int    done_ts = 0;
    prof_t cur_prof;

    rectify_sequencer #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(TMO),
        .XMAX          (639),
        .YMAX          (479)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .corners_valid(corners_valid),
        .corners_ready(corners_ready),
        .x1_in        (drive_q.x[0]),
        .x2_in        (drive_q.x[1]),
        .x3_in        (drive_q.x[2]),
        .x4_in        (drive_q.x[3]),
        .y1_in        (drive_q.y[0]),
        .y2_in        (drive_q.y[1]),
        .y3_in        (drive_q.y[2]),
        .y4_in        (drive_q.y[3]),
        .x1_out       (x1_out),
        .x2_out       (x2_out),
        .x3_out       (x3_out),
        .x4_out       (x4_out),
        .y1_out       (y1_out),
        .y2_out       (y2_out),
        .y3_out       (y3_out),
        .y4_out       (y4_out),
        .params_latch (params_latch),
        .xform_start  (xform_start),
        .xform_done   (xform_done),
        .bank_sel     (bank_sel),
        .busy         (busy),
        .frame_valid  (frame_valid),
        .err_range    (err_range),
        .err_timeout  (err_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic quad_t out_quad();
        quad_t q;
        q.x[0] = x1_out; q.x[1] = x2_out; q.x[2] = x3_out; q.x[3] = x4_out;
        q.y[0] = y1_out; q.y[1] = y2_out; q.y[2] = y3_out; q.y[3] = y4_out;
        return q;
    endfunction

    function automatic bit quad_ok(input quad_t q);
        for (int i = 0; i < 4; i++) begin
            if (int'(q.x[i]) > 639 || int'(q.y[i]) > 479) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic quad_t rand_quad(input bit make_bad);
        quad_t q;
        int    k;
        for (int i = 0; i < 4; i++) begin
            q.x[i] = 10'($urandom_range(639, 0));
            q.y[i] = 9'($urandom_range(479, 0));
        end
        if (make_bad) begin
            k = int'($urandom_range(7, 0));
            if (k < 4) q.x[k] = 10'($urandom_range(1023, 640));
            else       q.y[k-4] = 9'($urandom_range(511, 480));
        end
        return q;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_event(input ev_kind_t kind, input int lbl);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("[TB] FAIL unexpected_%s: got event at cycle %0d expected none", kind.name(), lbl);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.cyc != lbl) begin
                bad++;
                $display("[TB] FAIL event_order: got %s@%0d expected %s@%0d",
                         kind.name(), lbl, e.kind.name(), e.cyc);
            end else if (kind == EV_FRAME) begin
                checkOutput("bank_at_frame", 128'(bank_sel), 128'(e.bank));
            end
        end
    endtask

    // Pulse outputs are matched in order against the expected event queue.
    always @(negedge clk) begin : monitor
        int lbl;
        if (reset_n) begin
            lbl = cyc + 1;
            if (params_latch) check_event(EV_LATCH, lbl);
            if (xform_start)  check_event(EV_START, lbl);
            if (frame_valid)  check_event(EV_FRAME, lbl);
            if (err_range)    check_event(EV_RANGE, lbl);
            if (err_timeout)  check_event(EV_TMO, lbl);
        end
    end

    // Transform model: stale done for 'hold' cycles after start, low for 'low' cycles, then high.
    always @(posedge clk) begin : done_model
        int lbl;
        int rel;
        #1;
        if (!reset_n) begin
            done_active = 1'b0;
            xform_done  = 1'b0;
        end else begin
            lbl = cyc + 1;
            if (xform_start && prof_q.size() > 0) begin
                cur_prof    = prof_q.pop_front();
                done_ts     = lbl;
                done_active = 1'b1;
            end
            if (done_active) begin
                rel = lbl - done_ts;
                if (rel >= 1) begin
                    if (rel <= cur_prof.hold)                      xform_done = 1'b1;
                    else if (rel <= cur_prof.hold + cur_prof.low)  xform_done = 1'b0;
                    else                                           xform_done = 1'b1;
                end
            end
        end
    end

    task automatic applyStimulus(input quad_t q, input int hold, input int low, input bit drop);
        bit ok = 1'b0;
        int t;
        int ts;
        int b;
        drive_q       = q;
        corners_valid = 1'b1;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (corners_ready && corners_valid) begin
                ok = 1'b1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL handshake: got no accept expected accept within 2000 cycles");
        end
        t = cyc + 1;
        if (!quad_ok(q)) begin
            exp_q.push_back('{EV_RANGE, t + 1, 1'b0});
        end else begin
            ts      = t + S + 2;
            last_ts = ts;
            exp_q.push_back('{EV_LATCH, t + S + 1, 1'b0});
            exp_q.push_back('{EV_START, ts, 1'b0});
            prof_q.push_back('{hold, low});
            b = ts + hold + low + 1;
            if (hold < NEVER && b <= ts + TMO) begin
                exp_q.push_back('{EV_FRAME, b + 1, model_bank});
                model_bank = ~model_bank;
            end else begin
                exp_q.push_back('{EV_TMO, ts + TMO, 1'b0});
            end
            last_quad = q;
        end
        @(posedge clk);
        #1;
        if (quad_ok(q)) checkOutput("busy_after_accept", 128'(busy), 128'(1));
        else            checkOutput("ready_after_range", 128'(corners_ready), 128'(1));
        if (drop) corners_valid = 1'b0;
    endtask

    task automatic waitIdle(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && corners_ready) begin
                ok = 1'b1;
                break;
            end
        end
        checkOutput({name, "_drained"}, 128'(exp_q.size()), 128'(0));
        if (!ok) $display("[TB] FAIL %s_idle: got busy expected idle within 600 cycles", name);
        checkOutput({name, "_bank"}, 128'(bank_sel), 128'(model_bank));
        checkOutput({name, "_corners"}, 128'(out_quad()), 128'(last_quad));
        checkOutput({name, "_busy"}, 128'(busy), 128'(0));
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string name);
        checkOutput({name, "_ready"}, 128'(corners_ready), 128'(1));
        checkOutput({name, "_busy"}, 128'(busy), 128'(0));
        checkOutput({name, "_bank"}, 128'(bank_sel), 128'(0));
        checkOutput({name, "_pulses"},
                    128'({params_latch, xform_start, frame_valid, err_range, err_timeout}), 128'(0));
        checkOutput({name, "_corners"}, 128'(out_quad()), 128'(0));
    endtask

    initial begin : watchdog
        #800_000;
        bad++;
        $display("[TB] FAIL watchdog: got no finish expected finish before 80000 cycles");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        quad_t q;
        bit    ok;
        int    r;

        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] directed: full-frame corners, stale done then late rise");
        q.x[0] = 10'd0;   q.y[0] = 9'd0;
        q.x[1] = 10'd0;   q.y[1] = 9'd479;
        q.x[2] = 10'd639; q.y[2] = 9'd479;
        q.x[3] = 10'd639; q.y[3] = 9'd0;
        applyStimulus(q, 6, 50, 1'b1);
        waitIdle("frame1");

        $display("[TB] directed: range errors");
        q.x[2] = 10'd640;
        applyStimulus(q, 0, 1, 1'b1);
        waitIdle("x3_640");
        q.x[2] = 10'd639;
        q.y[1] = 9'd480;
        applyStimulus(q, 0, 1, 1'b1);
        waitIdle("y2_480");

        $display("[TB] directed: timeouts and done-wins boundary");
        q = rand_quad(1'b0);
        applyStimulus(q, NEVER, 1, 1'b1);
        waitIdle("never_falls");
        applyStimulus(rand_quad(1'b0), 4, 95, 1'b1);
        waitIdle("done_on_last");
        applyStimulus(rand_quad(1'b0), 4, 96, 1'b1);
        waitIdle("done_after_last");

        $display("[TB] directed: back-to-back with second quad held during busy");
        applyStimulus(rand_quad(1'b0), 3, 20, 1'b0);
        applyStimulus(rand_quad(1'b0), 2, 10, 1'b1);
        waitIdle("back_to_back");

        $display("[TB] random transactions");
        for (int n = 0; n < 25; n++) begin
            r = int'($urandom_range(99, 0));
            if (r < 20) begin
                applyStimulus(rand_quad(1'b1), 0, 1, 1'b1);
            end else if (r < 35) begin
                applyStimulus(rand_quad(1'b0), NEVER, 1, 1'b1);
            end else if (r < 50) begin
                applyStimulus(rand_quad(1'b0), int'($urandom_range(8, 0)),
                              int'($urandom_range(110, 88)), 1'b1);
            end else begin
                applyStimulus(rand_quad(1'b0), int'($urandom_range(8, 0)),
                              int'($urandom_range(60, 1)), 1'b1);
            end
            waitIdle("random");
        end

        $display("[TB] reset during RUN");
        if (model_bank == 1'b0) begin
            applyStimulus(rand_quad(1'b0), 1, 5, 1'b1);
            waitIdle("pre_reset");
        end
        applyStimulus(rand_quad(1'b0), 2, 60, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (cyc + 1 >= last_ts + 10) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        checkOutput("reach_run", 128'(ok), 128'(1));
        checkOutput("busy_in_run", 128'(busy), 128'(1));
        checkOutput("bank_before_reset", 128'(bank_sel), 128'(1));
        #2;
        reset_n = 1'b0;
        exp_q.delete();
        prof_q.delete();
        model_bank = 1'b0;
        last_quad  = '0;
        #1;
        check_reset_values("mid_reset");
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("ready_after_release", 128'(corners_ready), 128'(1));
        applyStimulus(rand_quad(1'b0), 3, 12, 1'b1);
        waitIdle("after_reset");

        checkOutput("leftover_events", 128'(exp_q.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
